// File: rtl/pipelined_control_unit_if.sv
// Control-unit bundle: ID-stage opcode and hazard inputs, staged control outputs
// and halt status. The core side drives as master; the control unit is the slave.
interface pipelined_control_unit_if;
  logic [6:0] Opcode;
  logic       stall;
  logic       flush;
  logic       ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic       ex_Branch;
  logic       ex_Jump;
  logic       ex_illegal;
  logic       mem_MemRead;
  logic       mem_MemWrite;
  logic       wb_RegWrite;
  logic       wb_MemtoReg;
  logic       pc_hold;
  logic       halt;

  modport master (
    output Opcode, stall, flush,
    input  ex_ALUSrc, ex_ALUOp, ex_Branch, ex_Jump, ex_illegal,
    input  mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
    input  pc_hold, halt
  );

  modport slave (
    input  Opcode, stall, flush,
    output ex_ALUSrc, ex_ALUOp, ex_Branch, ex_Jump, ex_illegal,
    output mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
    output pc_hold, halt
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined RISC-V control unit: decodes the ID opcode, stages the control word
// through ID/EX, EX/MEM and MEM/WB, and drains the pipeline before halting.
module pipelined_control_unit #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          EN_UPPER     = 1'b1,
  parameter logic [6:0]  HALT_OPCODE  = 7'b0000001
) (
  input  logic                     clk,
  input  logic                     reset,
  pipelined_control_unit_if.slave  bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       memto_reg;
    logic       halt;
  } ctrl_t;

  // Later stages only carry the fields they still consume.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic memto_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  ctrl_t     w_dec;
  ctrl_t     r_idex;
  mem_ctrl_t r_exmem;
  wb_ctrl_t  r_memwb;
  state_t    r_state;
  state_t    w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic      w_bubble;
  logic      w_pc_hold;
  logic      w_halt;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_dec = '0;
    if (bus.Opcode == HALT_OPCODE) begin
      w_dec.halt = 1'b1;
    end else begin
      unique case (bus.Opcode)
        OP_R: begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_op    = 2'b10;
        end
        OP_I: begin
          w_dec.alu_src   = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.alu_op    = 2'b10;
        end
        OP_LW: begin
          w_dec.alu_src   = 1'b1;
          w_dec.memto_reg = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.mem_read  = 1'b1;
        end
        OP_SW: begin
          w_dec.alu_src   = 1'b1;
          w_dec.mem_write = 1'b1;
        end
        OP_BR: begin
          w_dec.branch = 1'b1;
          w_dec.alu_op = 2'b01;
        end
        OP_JAL: begin
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.alu_op    = 2'b11;
        end
        OP_JALR: begin
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.alu_op    = 2'b11;
        end
        OP_LUI, OP_AUIPC: begin
          if (EN_UPPER) begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
          end else begin
            w_dec.illegal = 1'b1;
          end
        end
        OP_NOP: ;
        default: w_dec.illegal = 1'b1;
      endcase
    end
  end

  // Any hazard, or a halt in progress, replaces the ID instruction with a bubble.
  assign w_bubble = bus.stall | bus.flush | (r_state != S_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the stages shift in lockstep.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_idex  <= w_bubble ? '0 : w_dec;
      r_exmem <= '{mem_read:  r_idex.mem_read,
                   mem_write: r_idex.mem_write,
                   reg_write: r_idex.reg_write,
                   memto_reg: r_idex.memto_reg};
      r_memwb <= '{reg_write: r_exmem.reg_write,
                   memto_reg: r_exmem.memto_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (r_idex.halt) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HALTED: ;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_pc_hold = 1'b0;
    w_halt    = 1'b0;
    unique case (r_state)
      S_RUN: ;
      S_DRAIN:  w_pc_hold = 1'b1;
      S_HALTED: begin
        w_pc_hold = 1'b1;
        w_halt    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ex_ALUSrc    = r_idex.alu_src;
  assign bus.ex_ALUOp     = r_idex.alu_op;
  assign bus.ex_Branch    = r_idex.branch;
  assign bus.ex_Jump      = r_idex.jump;
  assign bus.ex_illegal   = r_idex.illegal;
  assign bus.mem_MemRead  = r_exmem.mem_read;
  assign bus.mem_MemWrite = r_exmem.mem_write;
  assign bus.wb_RegWrite  = r_memwb.reg_write;
  assign bus.wb_MemtoReg  = r_memwb.memto_reg;
  assign bus.pc_hold      = w_pc_hold;
  assign bus.halt         = w_halt;

endmodule
